colour_seq_ctrl: RTL and testbench

Sequencing controller for the dynamic-LED `lightcontrol` block. It accepts a target colour over a valid/ready handshake. It then drives `lightcontrol`'s `button` input one step at a time, watching the `colour` feedback until the target is shown, and reports `done` or `err`. When idle it passes the manual push-button through, so the board button and automated requesters share the one LED datapath.

---
 rtl/led_ctrl_pkg.sv | 24 ++
 rtl/colour_seq_ctrl.sv | 115 +++++++++++
 tb/tb_colour_seq_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED colour sequencing path: colour encoding,
// legal colour range and the sequencer FSM state set.
package led_ctrl_pkg;

    typedef logic [2:0] colour_t;

    localparam colour_t COLOUR_MIN = 3'd1;
    localparam colour_t COLOUR_MAX = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PULSE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } seq_state_e;

    // Only 1..6 are colours lightcontrol can settle on; 0 and 7 are transient.
    function automatic logic colour_legal(input colour_t c);
        return (c >= COLOUR_MIN) && (c <= COLOUR_MAX);
    endfunction

endpackage

// File: rtl/colour_seq_ctrl.sv
// Steps lightcontrol's button one pulse at a time until the colour feedback
// matches a requested target, then pulses done (or err on an illegal target
// or when the step budget runs out). In IDLE the board button passes through.
module colour_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int MAX_STEPS = 7,
    parameter int SETTLE    = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    btn_manual,
    input  logic    req_valid,
    input  colour_t req_colour,
    output logic    req_ready,
    input  colour_t colour_in,
    output logic    button_out,
    output logic    busy,
    output logic    done,
    output logic    err
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEPS);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);

    seq_state_e        state_q, state_d;
    colour_t           target_q, target_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;

    // State and counter registers; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            target_q     <= '0;
            step_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            step_cnt_q   <= step_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // Next-state logic and Moore outputs. All outputs are forced low while
    // rst is high so an abort never leaks a done/err pulse or a button edge.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        step_cnt_d   = step_cnt_q;
        settle_cnt_d = settle_cnt_q;
        req_ready    = 1'b0;
        button_out   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        err          = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy       = 1'b0;
                req_ready  = 1'b1;
                button_out = btn_manual;
                if (req_valid) begin
                    target_d   = req_colour;
                    step_cnt_d = '0;
                    state_d    = colour_legal(req_colour) ? CHECK : ERR;
                end
            end
            CHECK: begin
                if (colour_in == target_q)
                    state_d = DONE;
                else if (step_cnt_q == STEP_MAX)
                    state_d = ERR;
                else
                    state_d = PULSE;
            end
            PULSE: begin
                button_out   = 1'b1;
                settle_cnt_d = '0;
                if (step_cnt_q != STEP_MAX)
                    step_cnt_d = step_cnt_q + STEP_W'(1);
                state_d = WAIT;
            end
            WAIT: begin
                // Give lightcontrol SETTLE cycles before the next compare.
                if (settle_cnt_q == SET_LAST)
                    state_d = CHECK;
                else
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            req_ready  = 1'b0;
            button_out = 1'b0;
            busy       = 1'b0;
            done       = 1'b0;
            err        = 1'b0;
        end
    end

endmodule

// File: tb/tb_colour_seq_ctrl.sv
// Bench for colour_seq_ctrl driving a behavioural lightcontrol model.
// Requests push their expected outcome (kind, cycle, pulse count) into a
// scoreboard; a negedge monitor pops it when done/err appears.
module tb_colour_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lc_rst = 1'b1;
    logic       btn_manual = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_colour = 3'd0;
    logic       req_ready;
    logic [2:0] colour;
    logic       button_out;
    logic       busy;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        bit is_err;
        int cyc;
        int pulses;
    } exp_t;

    exp_t sb[$];

    colour_seq_ctrl #(.MAX_STEPS(7), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .btn_manual(btn_manual),
        .req_valid(req_valid), .req_colour(req_colour), .req_ready(req_ready),
        .colour_in(colour), .button_out(button_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // lightcontrol model: 1..6 cycle, 0/7 jump to 1
    always @(posedge clk) begin
        if (lc_rst)
            colour <= 3'd0;
        else if (button_out)
            colour <= (colour >= 3'd6 || colour == 3'd0) ? 3'd1 : colour + 3'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    int pulses = 0;
    bit prev_btn = 1'b0;
    bit chk_next = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pulses   = 0;
            prev_btn = 1'b0;
            chk_next = 1'b0;
        end else begin
            if (busy) begin
                chk("no_double_pulse", int'(prev_btn && button_out), 0);
                if (button_out) pulses++;
            end
            prev_btn = busy && button_out;
            if (done || err) begin
                chk("done_err_exclusive", int'(done && err), 0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_terminal: done=%0d err=%0d with empty scoreboard (cyc %0d)",
                             done, err, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("terminal_kind_err", int'(err), int'(e.is_err));
                    chk("terminal_cycle", cyc, e.cyc);
                    chk("pulse_count", pulses, e.pulses);
                end
                pulses   = 0;
                chk_next = 1'b1;
            end else if (chk_next) begin
                chk("busy_low_after", int'(busy), 0);
                chk("ready_after", int'(req_ready), 1);
                chk_next = 1'b0;
            end
        end
    end

    // Issue one request; off is the spec cycle offset from the handshake edge.
    task automatic do_req(input logic [2:0] c, input bit is_err, input int off,
                          input int np, input bit push);
        int k;
        exp_t e;
        @(negedge clk);
        chk("ready_before_req", int'(req_ready), 1);
        req_valid  = 1'b1;
        req_colour = c;
        @(posedge clk);
        #1;
        k = cyc;
        req_valid = 1'b0;
        chk("busy_after_hs", int'(busy), 1);
        if (push) begin
            e.is_err = is_err;
            e.cyc    = k + off - 1;
            e.pulses = np;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL wait_timeout: %0d entries still pending", sb.size());
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic press(input int n);
        repeat (n) begin
            @(negedge clk);
            btn_manual = 1'b1;
            #1 chk("manual_passthrough", int'(button_out), 1);
        end
        @(negedge clk);
        btn_manual = 1'b0;
    endtask

    initial begin
        // Reset with the manual button held: nothing may leak out.
        btn_manual = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_button", int'(button_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        btn_manual = 1'b0;
        rst    = 1'b0;
        lc_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(req_ready), 1);
        chk("led_reset", int'(colour), 0);

        // LED 0 -> 3: three pulses, done at k+11
        do_req(3'd3, 1'b0, 11, 3, 1'b1);
        wait_idle();
        chk("led_at_3", int'(colour), 3);

        // Manual presses to 5, request 5: done at k+2
        press(2);
        chk("led_at_5", int'(colour), 5);
        do_req(3'd5, 1'b0, 2, 0, 1'b1);
        wait_idle();

        // LED 6, request 1: wrap in one pulse, done at k+5
        press(1);
        chk("led_at_6", int'(colour), 6);
        do_req(3'd1, 1'b0, 5, 1, 1'b1);
        wait_idle();
        chk("led_at_1", int'(colour), 1);

        // Illegal targets: err at k+1, no pulse
        do_req(3'd7, 1'b1, 1, 0, 1'b1);
        wait_idle();
        do_req(3'd0, 1'b1, 1, 0, 1'b1);
        wait_idle();
        chk("led_unchanged", int'(colour), 1);

        // lightcontrol stuck in reset, manual button held: 7 pulses then err
        lc_rst = 1'b1;
        @(negedge clk);
        btn_manual = 1'b1;
        do_req(3'd4, 1'b1, 23, 7, 1'b1);
        wait_idle();
        btn_manual = 1'b0;
        lc_rst = 1'b0;
        @(negedge clk);

        // Abort in WAIT: handshake k, PULSE after k+1, WAIT after k+2
        do_req(3'd2, 1'b0, 0, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("in_wait_busy", int'(busy), 1);
        rst = 1'b1;
        #1 chk("rst_wait_button", int'(button_out), 0);
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready_in_rst", int'(req_ready), 0);
        chk("abort_button", int'(button_out), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", int'(req_ready), 1);
        chk("abort_idle", int'(busy), 0);
        chk("abort_no_pulse", int'(button_out), 0);
        repeat (8) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
